bus_sink: RTL and testbench
===========================

// Module: bus_sink
// PURPOSE
//  Receiving end of the wired-OR result bus. Each cycle every bus source drives
//  zero except the one selected source. This block captures bus_dat for the
//  destination of the current instruction and queues it in a 2-entry FIFO.
//  It drains the FIFO into the GPRF write port through a valid/ready handshake.
//  It back-pressures issue and flags driver-selection errors.
// PARAMETERS
//  DAT_W  `DAT_W (define.v)  bus / write-back data width
//  RA_W   5                  GPRF register address width
//  NSRC   6                  bus sources: imm, alu1, alu2, alu2_cry, ldst1, gprf
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  bus_dat    in   DAT_W  wired-OR result bus
//  src_oh     in   NSRC   per-source "driving bus this cycle" flags, one-hot expected
//  dst_we     in   1      capture request: bus_dat is destined for GPRF this cycle
//  dst_addr   in   RA_W   destination register for the capture
//  wb_rdy     in   1      GPRF write port accepts this cycle
//  wb_vld     out  1      FIFO head valid
//  wb_addr    out  RA_W   FIFO head address
//  wb_dat     out  DAT_W  FIFO head data
//  sink_full  out  1      FIFO holds 2 entries; issue must not assert dst_we unless wb accepts
//  col_err    out  1      sticky: capture with popcount(src_oh) != 1
//  ovf_err    out  1      sticky: capture dropped because FIFO was full
//  err_clr    in   1      clears col_err and ovf_err
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - cnt=0, read and write pointers=0.
//   - wb_vld=0, wb_addr=0, wb_dat=0, sink_full=0, col_err=0, ovf_err=0.
//   - FIFO storage is not reset.
//   - Reset mid-operation discards queued entries; no partial write is issued.
//  Events:
//   - push = dst_we.
//   - pop = wb_vld & wb_rdy.
//   - accept = push & (cnt<2 | pop).
//  Storage:
//   - 2-entry circular FIFO; 1-bit wr_ptr and rd_ptr, each toggles on its event.
//   - cnt in 0..2.
//   - cnt_next = cnt + accept - pop.
//  Push:
//   - Stores {dst_addr, bus_dat} sampled at the same rising edge.
//   - No combinational path from bus_dat to wb_dat.
//  Latency:
//   - Capture at edge N makes the entry visible at wb_* after edge N when the FIFO was empty.
//   - In that case wb_vld rises in cycle N+1.
//  Head outputs:
//   - wb_vld = (cnt!=0), registered.
//   - wb_addr and wb_dat = entry at rd_ptr.
//   - wb_addr and wb_dat hold stable while wb_vld=1 and wb_rdy=0.
//  Ordering:
//   - Strict FIFO; write-back order equals capture order.
//   - Two captures to the same address are both written, oldest first.
//  Full boundary:
//   - sink_full = (cnt==2), registered.
//   - Push while full with pop in the same cycle: accepted, cnt stays 2.
//   - Push while full without pop: data dropped, FIFO unchanged, ovf_err<=1.
//  Empty boundary:
//   - A pop cannot occur while empty (wb_vld=0).
//   - Push and pop with cnt=1: cnt stays 1, head advances to the new entry.
//  Collision check:
//   - Active only when dst_we=1: col_err<=1 if src_oh has zero bits set or more than one.
//   - The entry is still pushed with the raw OR value.
//  Error flags:
//   - col_err and ovf_err are sticky.
//   - err_clr=1 clears both at the next edge.
//   - A new error in the same cycle as err_clr wins: the flag is set.
//  src_oh and dst_addr are ignored when dst_we=0.
// TESTING
//  T1 Reset: rst_n=0 mid-stream with cnt=2 -> all outputs 0 immediately (async); after release wb_vld stays 0.
//  T2 Latency: empty FIFO, dst_we=1, addr=3, bus=0xA5A5, src_oh=6'b000010, wb_rdy=1 -> next cycle wb_vld=1, addr=3, dat=0xA5A5; following cycle wb_vld=0.
//  T3 Backpressure: wb_rdy=0, capture addr1=0x11 then addr2=0x22 -> sink_full=1 and head holds addr1/0x11; wb_rdy=1 -> 0x11 then 0x22 in order.
//  T4 Full edge: cnt=2, wb_rdy=1, push 0x33 -> accepted, cnt stays 2, no ovf_err. Same with wb_rdy=0 -> 0x33 dropped, ovf_err=1, queued data intact.
//  T5 Collision: dst_we=1 with src_oh=6'b000011 -> col_err=1, entry pushed. dst_we=1 with src_oh=0 -> col_err=1. dst_we=0 with src_oh=6'b111111 -> no error.
//  T6 Error clear: err_clr=1 with no new error -> flags 0. err_clr=1 with a same-cycle collision -> col_err stays 1.

Source files
------------

// File: rtl/bus_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bus_sink_if                                                  |
// | Brief  : Capture-side and write-back-side signals of the bus sink.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface bus_sink_if #(
    parameter int DAT_W = 16,
    parameter int RA_W  = 5,
    parameter int NSRC  = 6
);
    logic [DAT_W-1:0] bus_dat;
    logic [NSRC-1:0]  src_oh;
    logic             dst_we;
    logic [RA_W-1:0]  dst_addr;
    logic             wb_rdy;
    logic             wb_vld;
    logic [RA_W-1:0]  wb_addr;
    logic [DAT_W-1:0] wb_dat;
    logic             sink_full;
    logic             col_err;
    logic             ovf_err;
    logic             err_clr;

    modport slave (
        input  bus_dat, src_oh, dst_we, dst_addr, wb_rdy, err_clr,
        output wb_vld, wb_addr, wb_dat, sink_full, col_err, ovf_err
    );

    modport master (
        output bus_dat, src_oh, dst_we, dst_addr, wb_rdy, err_clr,
        input  wb_vld, wb_addr, wb_dat, sink_full, col_err, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bus_sink                                                     |
// | Brief  : Captures wired-OR result bus into a 2-entry FIFO and drains |
// |          it to the GPRF write port; flags collisions and overflow.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bus_sink #(
    parameter int DAT_W = 16,
    parameter int RA_W  = 5,
    parameter int NSRC  = 6
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bus_sink_if.slave     bus
);
    localparam int c_ENT_W = RA_W + DAT_W;

    logic [c_ENT_W-1:0] r_mem [2];
    logic [1:0]         r_cnt;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_vld;
    logic               r_full;
    logic               r_col_err;
    logic               r_ovf_err;

    logic               w_push;
    logic               w_pop;
    logic               w_accept;
    logic               w_col;
    logic               w_ovf;
    logic [1:0]         w_cnt_nxt;
    logic [c_ENT_W-1:0] w_head;

    always_comb begin
        w_push    = bus.dst_we;
        w_pop     = r_vld & bus.wb_rdy;
        w_accept  = w_push & ((r_cnt != 2'd2) | w_pop);
        w_col     = w_push & ~$onehot(bus.src_oh);
        w_ovf     = w_push & ~w_accept;
        w_cnt_nxt = r_cnt + {1'b0, w_accept} - {1'b0, w_pop};
        w_head    = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_vld     <= 1'b0;
            r_full    <= 1'b0;
            r_col_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_vld  <= (w_cnt_nxt != 2'd0);
            r_full <= (w_cnt_nxt == 2'd2);
            if (w_accept) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
            // a fresh error outranks a simultaneous clear
            if (w_col)             r_col_err <= 1'b1;
            else if (bus.err_clr)  r_col_err <= 1'b0;
            if (w_ovf)             r_ovf_err <= 1'b1;
            else if (bus.err_clr)  r_ovf_err <= 1'b0;
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= {bus.dst_addr, bus.bus_dat};
    end

    assign bus.wb_vld    = r_vld;
    assign bus.wb_addr   = r_vld ? w_head[c_ENT_W-1:DAT_W] : '0;
    assign bus.wb_dat    = r_vld ? w_head[DAT_W-1:0]       : '0;
    assign bus.sink_full = r_full;
    assign bus.col_err   = r_col_err;
    assign bus.ovf_err   = r_ovf_err;
endmodule
`default_nettype wire

// File: tb/tb_bus_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_bus_sink                                                  |
// | Brief  : Directed and randomized bench for bus_sink with queue model.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_bus_sink;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NS = 6;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic [AW+DW-1:0] mq[$];
    logic             m_col;
    logic             m_ovf;

    bus_sink_if #(.DAT_W(DW), .RA_W(AW), .NSRC(NS)) bi ();

    bus_sink #(.DAT_W(DW), .RA_W(AW), .NSRC(NS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of stimulus and advances the reference model at the edge.
    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NS-1:0] oh, input logic rdy, input logic clr);
        logic pop;
        logic acc;
        bi.dst_we   = we;
        bi.dst_addr = a;
        bi.bus_dat  = d;
        bi.src_oh   = oh;
        bi.wb_rdy   = rdy;
        bi.err_clr  = clr;
        @(posedge clk);
        pop = (mq.size() != 0) && rdy;
        acc = we && ((mq.size() < 2) || pop);
        if (we && ($countones(oh) != 1)) m_col = 1'b1;
        else if (clr)                    m_col = 1'b0;
        if (we && !acc)                  m_ovf = 1'b1;
        else if (clr)                    m_ovf = 1'b0;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({a, d});
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bi.dst_we = 1'b0; bi.dst_addr = '0; bi.bus_dat = '0;
        bi.src_oh = '0; bi.wb_rdy = 1'b0; bi.err_clr = 1'b0;
        mq.delete(); m_col = 1'b0; m_ovf = 1'b0;
        #12;
        n_checks++;
        if ({bi.wb_vld, bi.wb_addr, bi.wb_dat} !== {1'b0, 5'd0, 16'd0})
            $display("FAIL reset_head got %h exp 0", {bi.wb_vld, bi.wb_addr, bi.wb_dat});
        else n_pass++;
        n_checks++;
        if ({bi.sink_full, bi.col_err, bi.ovf_err} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {bi.sink_full, bi.col_err, bi.ovf_err});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        drive(1'b1, 5'd3, 16'hA5A5, 6'b000010, 1'b1, 1'b0);
        n_checks++;
        if ({bi.wb_vld, bi.wb_addr, bi.wb_dat} !== {1'b1, 5'd3, 16'hA5A5})
            $display("FAIL latency_head got %h exp %h", {bi.wb_vld, bi.wb_addr, bi.wb_dat},
                     {1'b1, 5'd3, 16'hA5A5});
        else n_pass++;
        idle(1'b1);
        n_checks++;
        if (bi.wb_vld !== 1'b0) $display("FAIL latency_drain got %b exp 0", bi.wb_vld);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        drive(1'b1, 5'd1, 16'h0011, 6'b000001, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 16'h0022, 6'b010000, 1'b0, 1'b0);
        n_checks++;
        if ({bi.sink_full, bi.wb_vld, bi.wb_addr, bi.wb_dat} !== {2'b11, 5'd1, 16'h0011})
            $display("FAIL bp_full_head got %h exp %h",
                     {bi.sink_full, bi.wb_vld, bi.wb_addr, bi.wb_dat}, {2'b11, 5'd1, 16'h0011});
        else n_pass++;
        idle(1'b0);
        n_checks++;
        if ({bi.wb_addr, bi.wb_dat} !== {5'd1, 16'h0011})
            $display("FAIL bp_hold got %h exp %h", {bi.wb_addr, bi.wb_dat}, {5'd1, 16'h0011});
        else n_pass++;
        idle(1'b1);
        n_checks++;
        if ({bi.sink_full, bi.wb_vld, bi.wb_addr, bi.wb_dat} !== {2'b01, 5'd2, 16'h0022})
            $display("FAIL bp_second got %h exp %h",
                     {bi.sink_full, bi.wb_vld, bi.wb_addr, bi.wb_dat}, {2'b01, 5'd2, 16'h0022});
        else n_pass++;
        idle(1'b1);
        n_checks++;
        if (bi.wb_vld !== 1'b0) $display("FAIL bp_empty got %b exp 0", bi.wb_vld);
        else n_pass++;
    endtask

    task automatic test_full_edge;
        drive(1'b1, 5'd4, 16'h0044, 6'b000100, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 16'h0055, 6'b000100, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 16'h0033, 6'b000100, 1'b1, 1'b0);
        n_checks++;
        if ({bi.sink_full, bi.ovf_err, bi.wb_addr, bi.wb_dat} !== {2'b10, 5'd5, 16'h0055})
            $display("FAIL full_push_pop got %h exp %h",
                     {bi.sink_full, bi.ovf_err, bi.wb_addr, bi.wb_dat}, {2'b10, 5'd5, 16'h0055});
        else n_pass++;
        drive(1'b1, 5'd6, 16'h0066, 6'b000100, 1'b0, 1'b0);
        n_checks++;
        if ({bi.sink_full, bi.ovf_err, bi.wb_addr, bi.wb_dat} !== {2'b11, 5'd5, 16'h0055})
            $display("FAIL full_drop got %h exp %h",
                     {bi.sink_full, bi.ovf_err, bi.wb_addr, bi.wb_dat}, {2'b11, 5'd5, 16'h0055});
        else n_pass++;
        idle(1'b1);
        n_checks++;
        if ({bi.wb_vld, bi.ovf_err, bi.wb_addr, bi.wb_dat} !== {2'b11, 5'd3, 16'h0033})
            $display("FAIL full_intact got %h exp %h",
                     {bi.wb_vld, bi.ovf_err, bi.wb_addr, bi.wb_dat}, {2'b11, 5'd3, 16'h0033});
        else n_pass++;
        idle(1'b1);
        n_checks++;
        if (bi.wb_vld !== 1'b0) $display("FAIL full_empty got %b exp 0", bi.wb_vld);
        else n_pass++;
    endtask

    task automatic test_collision;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        drive(1'b1, 5'd7, 16'h1234, 6'b000011, 1'b1, 1'b0);
        n_checks++;
        if ({bi.col_err, bi.wb_vld, bi.wb_addr, bi.wb_dat} !== {2'b11, 5'd7, 16'h1234})
            $display("FAIL col_multi got %h exp %h",
                     {bi.col_err, bi.wb_vld, bi.wb_addr, bi.wb_dat}, {2'b11, 5'd7, 16'h1234});
        else n_pass++;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        n_checks++;
        if ({bi.col_err, bi.ovf_err} !== 2'b00)
            $display("FAIL clr_plain got %b exp 00", {bi.col_err, bi.ovf_err});
        else n_pass++;
        drive(1'b1, 5'd8, 16'h0000, 6'b000000, 1'b1, 1'b0);
        n_checks++;
        if (bi.col_err !== 1'b1) $display("FAIL col_zero got %b exp 1", bi.col_err);
        else n_pass++;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        drive(1'b0, 5'd9, 16'hFFFF, 6'b111111, 1'b1, 1'b0);
        n_checks++;
        if (bi.col_err !== 1'b0) $display("FAIL col_idle got %b exp 0", bi.col_err);
        else n_pass++;
    endtask

    task automatic test_err_clr;
        drive(1'b1, 5'd10, 16'h0AAA, 6'b100001, 1'b1, 1'b1);
        n_checks++;
        if (bi.col_err !== 1'b1) $display("FAIL clr_same_cycle got %b exp 1", bi.col_err);
        else n_pass++;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        n_checks++;
        if ({bi.col_err, bi.wb_vld} !== 2'b00)
            $display("FAIL clr_after got %b exp 00", {bi.col_err, bi.wb_vld});
        else n_pass++;
    endtask

    task automatic test_random;
        logic [AW+DW+3:0] exp_v;
        logic [AW+DW+3:0] got_v;
        logic [NS-1:0]    oh;
        for (int i = 0; i < 400; i++) begin
            oh = ($urandom_range(0, 9) == 0) ? NS'($urandom) : NS'(1 << $urandom_range(0, NS - 1));
            drive($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), oh,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
            exp_v = {mq.size() != 0, mq.size() == 2, m_col, m_ovf,
                     (mq.size() != 0) ? mq[0] : {(AW + DW){1'b0}}};
            got_v = {bi.wb_vld, bi.sink_full, bi.col_err, bi.ovf_err, bi.wb_addr, bi.wb_dat};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL random_%0d got %h exp %h", i, got_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 5'd11, 16'hBEEF, 6'b001000, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 16'hCAFE, 6'b001000, 1'b0, 1'b0);
        drive(1'b1, 5'd13, 16'hDEAD, 6'b000000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bi.wb_vld, bi.sink_full, bi.col_err, bi.ovf_err, bi.wb_addr, bi.wb_dat} !== '0)
            $display("FAIL reset_async got %h exp 0",
                     {bi.wb_vld, bi.sink_full, bi.col_err, bi.ovf_err, bi.wb_addr, bi.wb_dat});
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mq.delete(); m_col = 1'b0; m_ovf = 1'b0;
        idle(1'b1);
        idle(1'b1);
        n_checks++;
        if ({bi.wb_vld, bi.sink_full} !== 2'b00)
            $display("FAIL reset_release got %b exp 00", {bi.wb_vld, bi.sink_full});
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_latency();
        test_backpressure();
        test_full_edge();
        test_collision();
        test_err_clr();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
